// File: rtl/shreg_pkg.sv
// Shared types for the universal shift register: operation codes and FSM states.
package shreg_pkg;

    typedef enum logic [1:0] {
        OP_NOP  = 2'b00,
        OP_LOAD = 2'b01,
        OP_SHL  = 2'b10,
        OP_SHR  = 2'b11
    } op_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/shreg_univ_if.sv
// Request/result bundle between an op-issuing controller (master) and shreg_univ (slave).
import shreg_pkg::*;

interface shreg_univ_if #(
    parameter int unsigned WIDTH = 8
);
    localparam int unsigned AW = $clog2(WIDTH + 1);

    logic             start;
    op_t              op;
    logic [AW-1:0]    amt;
    logic             rot;
    logic [WIDTH-1:0] d;
    logic             si;
    logic [WIDTH-1:0] q;
    logic             so;
    logic             busy;
    logic             done;

    modport master (output start, op, amt, rot, d, si, input q, so, busy, done);
    modport slave  (input start, op, amt, rot, d, si, output q, so, busy, done);
endinterface

// File: rtl/shreg_step.sv
// Combinational one-bit shift step; dir=0 shifts left, dir=1 shifts right.
module shreg_step #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] q,
    input  logic             dir,
    input  logic             fill,
    output logic [WIDTH-1:0] q_next,
    output logic             out_bit
);

    always_comb begin
        if (dir) begin
            q_next  = {fill, q[WIDTH-1:1]};
            out_bit = q[0];
        end else begin
            q_next  = {q[WIDTH-2:0], fill};
            out_bit = q[WIDTH-1];
        end
    end

endmodule

// File: rtl/shreg_univ.sv
// Sequential universal shift register: load, multi-step SHL/SHR one bit per clock, start/busy/done.
// Optional feature: define SHREG_ROTATE_EN to let rot=1 turn shifts into rotates.
import shreg_pkg::*;

module shreg_univ #(
    parameter int unsigned WIDTH = 8
) (
    input logic         clk,
    input logic         nrst,
    shreg_univ_if.slave bus
);

    localparam int unsigned AW = $clog2(WIDTH + 1);

    state_t           state, state_nx;
    logic [AW-1:0]    cnt, cnt_nx;
    op_t              op_l, op_l_nx;
    logic [WIDTH-1:0] q, q_nx;
    logic             so, so_nx;
    logic             busy, busy_nx;
    logic             done, done_nx;

    logic             dir;
    logic             fill;
    logic [WIDTH-1:0] step_q;
    logic             step_out;

    assign dir = (op_l == OP_SHR);

`ifdef SHREG_ROTATE_EN
    logic rot_l, rot_l_nx;

    // Rotate feeds back the bit about to leave, taken straight from q to keep the path acyclic.
    assign fill = rot_l ? (dir ? q[0] : q[WIDTH-1]) : bus.si;
`else
    assign fill = bus.si;
`endif

    shreg_step #(.WIDTH(WIDTH)) u_step (
        .q       (q),
        .dir     (dir),
        .fill    (fill),
        .q_next  (step_q),
        .out_bit (step_out)
    );

    // State and output registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            op_l  <= OP_NOP;
            q     <= '0;
            so    <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
`ifdef SHREG_ROTATE_EN
            rot_l <= 1'b0;
`endif
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            op_l  <= op_l_nx;
            q     <= q_nx;
            so    <= so_nx;
            busy  <= busy_nx;
            done  <= done_nx;
`ifdef SHREG_ROTATE_EN
            rot_l <= rot_l_nx;
`endif
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        op_l_nx  = op_l;
        q_nx     = q;
        so_nx    = so;
        busy_nx  = busy;
        done_nx  = 1'b0;
`ifdef SHREG_ROTATE_EN
        rot_l_nx = rot_l;
`endif
        unique case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    op_l_nx = bus.op;
`ifdef SHREG_ROTATE_EN
                    rot_l_nx = bus.rot;
`endif
                    unique case (bus.op)
                        OP_NOP:  done_nx = 1'b1;
                        OP_LOAD: begin
                            q_nx    = bus.d;
                            done_nx = 1'b1;
                        end
                        OP_SHL, OP_SHR: begin
                            if (bus.amt == '0) begin
                                done_nx = 1'b1;
                            end else begin
                                state_nx = ST_SHIFT;
                                cnt_nx   = bus.amt;
                                busy_nx  = 1'b1;
                            end
                        end
                        default: done_nx = 1'b1;
                    endcase
                end
            end
            ST_SHIFT: begin
                q_nx   = step_q;
                so_nx  = step_out;
                cnt_nx = cnt - AW'(1);
                if (cnt == AW'(1)) begin
                    state_nx = ST_IDLE;
                    busy_nx  = 1'b0;
                    done_nx  = 1'b1;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    assign bus.q    = q;
    assign bus.so   = so;
    assign bus.busy = busy;
    assign bus.done = done;

`ifndef SHREG_ROTATE_EN
    logic unused_rot;
    assign unused_rot = bus.rot;
`endif

endmodule
